// File: rtl/dmem_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_responder_if : request/response bus between the core MEM stage and
//                     the data-memory responder.
// Revision 1.0
// ----------------------------------------------------------------------------
interface dmem_responder_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [1:0]       req_size;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_responder : fixed-latency byte/half/word data memory, one request
//                  outstanding, right-aligned zero-filled load data.
// Revision 1.0
// ----------------------------------------------------------------------------
module dmem_responder #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input wire logic        clk,
  input wire logic        rst,
  dmem_responder_if.slave io_bus
);
  localparam int c_AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic             w_accept;
  logic             w_commit;

  logic             r_write;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [1:0]       r_size;

  logic             w_c_write;
  logic [WIDTH-1:0] w_c_addr;
  logic [WIDTH-1:0] w_c_wdata;
  logic [1:0]       w_c_size;

  logic             w_err;
  logic [c_AW-1:0]  w_idx;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_lanes;
  logic [WIDTH-1:0] w_load;

  logic [WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic             r_resp_valid;
  logic             r_resp_err;
  logic [WIDTH-1:0] r_resp_rdata;

  assign io_bus.req_ready  = !rst && ((r_state == IDLE) || (r_state == RESP));
  assign w_accept          = io_bus.req_valid && io_bus.req_ready;
  assign io_bus.resp_valid = r_resp_valid;
  assign io_bus.resp_err   = r_resp_err;
  assign io_bus.resp_rdata = r_resp_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      IDLE, RESP: begin
        if (w_accept) begin
          w_cnt_nxt = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = WAIT;
          end
        end else if (r_state == RESP) begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = RESP;
          w_commit    = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // A reset edge must never commit a pending store.
    if (rst) begin
      w_commit = 1'b0;
    end
  end

  // With single-cycle latency the commit happens on the accept edge itself,
  // so the request is taken straight from the bus instead of the registers.
  always_comb begin
    if (LATENCY == 1) begin
      w_c_write = io_bus.req_write;
      w_c_addr  = io_bus.req_addr;
      w_c_wdata = io_bus.req_wdata;
      w_c_size  = io_bus.req_size;
    end else begin
      w_c_write = r_write;
      w_c_addr  = r_addr;
      w_c_wdata = r_wdata;
      w_c_size  = r_size;
    end
  end

  assign w_idx   = w_c_addr[c_AW+1:2];
  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_c_addr[1:0], 3'b000};

  always_comb begin
    w_err   = (w_c_addr[WIDTH-1:c_AW+2] != '0);
    w_be    = 4'b0000;
    w_lanes = w_c_wdata;
    w_load  = '0;
    case (w_c_size)
      2'b00: begin
        w_be    = 4'b0001 << w_c_addr[1:0];
        w_lanes = WIDTH'({4{w_c_wdata[7:0]}});
        w_load  = WIDTH'(w_shift[7:0]);
      end
      2'b01: begin
        if (w_c_addr[0]) begin
          w_err = 1'b1;
        end
        w_be    = w_c_addr[1] ? 4'b1100 : 4'b0011;
        w_lanes = WIDTH'({2{w_c_wdata[15:0]}});
        w_load  = WIDTH'(w_shift[15:0]);
      end
      2'b10: begin
        if (w_c_addr[1:0] != 2'b00) begin
          w_err = 1'b1;
        end
        w_be    = 4'b1111;
        w_lanes = w_c_wdata;
        w_load  = w_word;
      end
      default: w_err = 1'b1;
    endcase
  end

  // Array is deliberately outside reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_commit && !w_err && w_c_write) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_lanes[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= 2'b00;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_write <= io_bus.req_write;
        r_addr  <= io_bus.req_addr;
        r_wdata <= io_bus.req_wdata;
        r_size  <= io_bus.req_size;
      end
      r_resp_valid <= w_commit;
      r_resp_err   <= w_commit && w_err;
      r_resp_rdata <= (w_commit && !w_err && !w_c_write) ? w_load : '0;
    end
  end
endmodule
`default_nettype wire
